data_memory_responder: RTL

DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

---
 rtl/mem_resp_pkg.sv | 21 ++
 rtl/mem_word_array.sv | 30 +++
 rtl/data_memory_responder.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the data memory responder: FSM states, error read data, defaults.
// Also holds the address check used to classify a request as misaligned or out of range.
package mem_resp_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      RESP  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   localparam logic [31:0] MEM_ERR_RD_DATA = 32'h0;
   localparam int          DEF_DEPTH       = 256;
   localparam int          DEF_LATENCY     = 2;

   // aw is log2 of the word depth; any byte address at or above 4*DEPTH has bits set above aw+1.
   function automatic logic addr_bad(input logic [31:0] addr, input int aw);
      return (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != 32'h0);
   endfunction

endpackage

// File: rtl/mem_word_array.sv
// Word storage: one synchronous write port shared by two writers (hi wins on the same word), combinational read.
// Contents are never reset.
module mem_word_array
   import mem_resp_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          hi_we_i,
   input  logic [AW-1:0] hi_addr_i,
   input  logic [31:0]   hi_data_i,
   input  logic          lo_we_i,
   input  logic [AW-1:0] lo_addr_i,
   input  logic [31:0]   lo_data_i,
   input  logic [AW-1:0] rd_addr_i,
   output logic [31:0]   rd_data_o
);

   logic [31:0] mem_q [DEPTH];

   // The later assignment takes effect, so the hi writer overrides lo on a collision.
   always_ff @(posedge clk_i) begin
      if (lo_we_i) mem_q[lo_addr_i] <= lo_data_i;
      if (hi_we_i) mem_q[hi_addr_i] <= hi_data_i;
   end

   assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/data_memory_responder.sv
// Word-addressed memory responder: accepts one request in IDLE, acks LATENCY+1 cycles later with data/err.
// A valid still held after the ack parks the FSM in DRAIN so the same request is never served twice.
module data_memory_responder
   import mem_resp_pkg::*;
#(
   parameter int DEPTH   = DEF_DEPTH,
   parameter int LATENCY = DEF_LATENCY
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [31:0]              mem_rd_addr,
   input  logic [31:0]              mem_wr_addr,
   input  logic [31:0]              mem_wr_data,
   input  logic                     mem_rd_wr,
   input  logic                     mem_req_valid,
   output logic [31:0]              mem_rd_data,
   output logic                     mem_ack,
   output logic                     mem_err,
   input  logic                     bd_wr_en,
   input  logic [$clog2(DEPTH)-1:0] bd_addr,
   input  logic [31:0]              bd_wr_data,
   output logic [15:0]              rd_count,
   output logic [15:0]              wr_count
);

   localparam int         AW       = $clog2(DEPTH);
   localparam logic [3:0] LAT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

   state_t        state_q;
   logic [3:0]    cnt_q;
   logic          wr_q;
   logic [31:0]   addr_q;
   logic [31:0]   wdata_q;
   logic          ack_q;
   logic          err_q;
   logic [31:0]   rd_data_q;
   logic [15:0]   rd_count_q, rd_count_d;
   logic [15:0]   wr_count_q, wr_count_d;

   logic          req_err;
   logic [AW-1:0] word_idx;
   logic          fn_we;
   logic [31:0]   arr_rd_data;

   assign req_err    = addr_bad(addr_q, AW);
   assign word_idx   = addr_q[AW+1:2];
   assign fn_we      = (state_q == RESP) && wr_q && !req_err;
   assign rd_count_d = (rd_count_q == 16'hFFFF) ? rd_count_q : rd_count_q + 16'd1;
   assign wr_count_d = (wr_count_q == 16'hFFFF) ? wr_count_q : wr_count_q + 16'd1;

   mem_word_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_array (
      .clk_i     (clk),
      .hi_we_i   (fn_we),
      .hi_addr_i (word_idx),
      .hi_data_i (wdata_q),
      .lo_we_i   (bd_wr_en),
      .lo_addr_i (bd_addr),
      .lo_data_i (bd_wr_data),
      .rd_addr_i (word_idx),
      .rd_data_o (arr_rd_data)
   );

   // RESP is the state whose closing edge commits the write and raises ack; the ack cycle itself is spent in DRAIN.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         cnt_q      <= 4'd0;
         wr_q       <= 1'b0;
         addr_q     <= 32'h0;
         wdata_q    <= 32'h0;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
         rd_data_q  <= MEM_ERR_RD_DATA;
         rd_count_q <= 16'h0;
         wr_count_q <= 16'h0;
      end else begin
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
         rd_data_q <= MEM_ERR_RD_DATA;
         case (state_q)
            IDLE: begin
               if (mem_req_valid) begin
                  wr_q    <= mem_rd_wr;
                  addr_q  <= mem_rd_wr ? mem_wr_addr : mem_rd_addr;
                  wdata_q <= mem_wr_data;
                  if (LATENCY == 0) begin
                     state_q <= RESP;
                  end else begin
                     state_q <= WAIT;
                     cnt_q   <= LAT_LOAD;
                  end
               end
            end
            WAIT: begin
               if (cnt_q == 4'd0) state_q <= RESP;
               else               cnt_q   <= cnt_q - 4'd1;
            end
            RESP: begin
               ack_q     <= 1'b1;
               err_q     <= req_err;
               rd_data_q <= (!wr_q && !req_err) ? arr_rd_data : MEM_ERR_RD_DATA;
               if (!req_err) begin
                  if (wr_q) wr_count_q <= wr_count_d;
                  else      rd_count_q <= rd_count_d;
               end
               state_q <= DRAIN;
            end
            DRAIN: begin
               if (!mem_req_valid) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign mem_ack     = ack_q;
   assign mem_err     = err_q;
   assign mem_rd_data = rd_data_q;
   assign rd_count    = rd_count_q;
   assign wr_count    = wr_count_q;

endmodule
